sb_loopback_tester: RTL and testbench
=====================================

# sb_loopback_tester

Switchboard traffic initiator and checker that exercises an incrementing loopback responder. It drives a deterministic byte-pattern packet stream onto an SB output, then receives the returned stream on an SB input. Each returned word is checked against the regenerated pattern plus the responder's fixed byte increment. It sits in example and regression benches opposite the loopback block and reports pass/fail plus counters to the test harness.

## Interface
- DW, 256: data width in bits; multiple of 8.
- INCREMENT, 8'd1: per-byte increment the responder is expected to apply.
- NUM_PKTS, 32'd16: words per run; must be ≥1.
- BURST_LEN, 32'd4: words per `last`-terminated group; must be ≥1.
- DEST, 32'h0: value driven on `tx_dest` and expected on `rx_dest`.

Ports:
- clk  input  1  clock
- nreset  input  1  asynchronous active-low reset
- start  input  1  pulse; begins a run from IDLE or DONE
- tx_data  output  DW  outgoing word
- tx_dest  output  32  outgoing destination
- tx_last  output  1  end of group
- tx_valid  output  1  outgoing word valid
- tx_ready  input  1  responder accepts word
- rx_data  input  DW  returned word
- rx_dest  input  32  returned destination
- rx_last  input  1  returned end of group
- rx_valid  input  1  returned word valid
- rx_ready  output  1  tester accepts returned word
- busy  output  1  state is RUN
- done  output  1  state is DONE
- pass  output  1  done and err_count==0
- err_count  output  16  mismatching words, saturating at 16'hFFFF
- tx_count  output  32  words sent this run
- rx_count  output  32  words received this run

## Operation
- The pattern for word n uses byte i = (n + i) mod 256.
- The expected returned byte i is (n + i + INCREMENT) mod 256, using 8-bit wraparound.
- last(n) = ((n+1) mod BURST_LEN == 0) || (n == NUM_PKTS-1). `tx_last` is driven with this value and `rx_last` is checked against it.
- `tx_data`, `tx_dest` and `tx_last` are combinational from `tx_count`. Expected values are regenerated from `rx_count`; the block has no FIFO.
- State machine: IDLE, RUN, DONE.
  - IDLE→RUN on `start`: clears tx_count, rx_count and err_count.
  - RUN→DONE on the rx handshake that makes rx_count == NUM_PKTS.
  - DONE→RUN on `start`: counters are cleared again.
  - `start` is ignored while in RUN.
- `tx_valid` = RUN && tx_count < NUM_PKTS. tx_count increments on tx_valid && tx_ready.
- `rx_ready` is 0 in IDLE and 1 in RUN and DONE.
- Each rx handshake in RUN compares data, dest and last. Any difference increments err_count by exactly 1 per word, regardless of how many fields or bytes differ. rx_count then increments.
- An rx beat in DONE is unexpected:
  - err_count increments and pass drops.
  - rx_count does not change.
- The block tolerates rx words arriving while tx is still sending, so the responder may be combinational.

## Timing
- Reset values: state IDLE, tx_valid 0, tx_last 0 (tx_count 0 gives last(0) only when BURST_LEN==1 or NUM_PKTS==1, but tx_valid is 0), tx_data 0-pattern, tx_dest DEST, rx_ready 0, busy 0, done 0, pass 0, all counters 0.
- `start` is sampled at edge k. busy and tx_valid are 1 from cycle k+1.
- done and pass rise in the cycle after the final rx handshake.
- Once tx_valid is asserted, it and the tx payload hold stable until the handshake.
- A simultaneous tx and rx handshake in one cycle updates both counters.
- When err_count is at 16'hFFFF, it holds.
- Asserting nreset mid-run returns every output to its reset value immediately. Any partial run is discarded.

## Configuration
- `SB_LOOPBACK_TESTER_STALL_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances every cycle in RUN.
  - rx_ready is 0 in RUN when lfsr[0]==0.
  - A new tx word is not offered in a cycle where lfsr[1]==0. This gating applies only while no offer is pending, so the hold rule is preserved.
- Not defined: no LFSR is present. rx_ready is 1 in RUN and tx_valid is continuous.

## Test plan
- DW=32, NUM_PKTS=4, BURST_LEN=2, paired with a loopback using INCREMENT=1. Pulse start → tx words 32'h03020100, 32'h04030201, …; tx_last on words 1 and 3; done=1, pass=1, err_count=0, tx_count=rx_count=4.
- Same setup, but the responder uses increment 2 → err_count=4, pass=0, done=1.
- tx_ready held 0 for 10 cycles after start → tx_valid stays 1 with tx_data 32'h03020100, and tx_count=0. On release, the run completes with pass=1.
- nreset pulsed after 2 words → all outputs return to reset values. A fresh start then completes with pass=1.
- Start in DONE → counters clear and a second run passes. An injected extra rx beat in DONE → err_count=1, pass=0, rx_count unchanged.
- With STALL_EN, NUM_PKTS=64 → pass=1, and at least one cycle each of rx_ready=0 and a tx gap is observed.

Source files
------------

// File: rtl/sb_loopback_tester.sv
// sb_loopback_tester: drives an incrementing byte-pattern packet stream out on
// the tx side and checks the stream returned on the rx side against the same
// pattern plus a fixed per-byte increment.
// Optional build macro: SB_LOOPBACK_TESTER_STALL_EN adds LFSR-driven stalls on
// both the tx offer and rx_ready.
module sb_loopback_tester #(
  parameter int          DW        = 256,
  parameter logic [7:0]  INCREMENT = 8'd1,
  parameter logic [31:0] NUM_PKTS  = 32'd16,
  parameter logic [31:0] BURST_LEN = 32'd4,
  parameter logic [31:0] DEST      = 32'h0
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          start,
  output logic [DW-1:0] tx_data,
  output logic [31:0]   tx_dest,
  output logic          tx_last,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [DW-1:0] rx_data,
  input  logic [31:0]   rx_dest,
  input  logic          rx_last,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
  output logic [31:0]   tx_count,
  output logic [31:0]   rx_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   txCount_q, txCount_d;
  logic [31:0]   rxCount_q, rxCount_d;
  logic [15:0]   errCount_q, errCount_d;
  logic          txHandshake, rxHandshake, clearCounts, rxMismatch;
  logic          txAllow, rxAllow;
  logic [DW-1:0] txPattern, rxExpected;

  // Word n ends a group at every BURST_LEN-th word and at the final word.
  function automatic logic lastOf(input logic [31:0] n);
    return (((n + 32'd1) % BURST_LEN) == 32'd0) || (n == NUM_PKTS - 32'd1);
  endfunction

`ifdef SB_LOOPBACK_TESTER_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        offerPending_q, offerPending_d;

  // Advance the stall LFSR only while running; remember an unaccepted offer so it is never withdrawn.
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == RUN)
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    offerPending_d = tx_valid && !tx_ready;
  end

  // Stall LFSR and pending-offer registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      lfsr_q         <= 16'hACE1;
      offerPending_q <= 1'b0;
    end else begin
      lfsr_q         <= lfsr_d;
      offerPending_q <= offerPending_d;
    end
  end

  assign rxAllow = lfsr_q[0];
  assign txAllow = offerPending_q || lfsr_q[1];
`else
  assign rxAllow = 1'b1;
  assign txAllow = 1'b1;
`endif

  assign txHandshake = tx_valid && tx_ready;
  assign rxHandshake = rx_valid && rx_ready;
  assign clearCounts = (state_q != RUN) && start;

  // Regenerate the outgoing pattern from tx_count and the expected return from rx_count.
  always_comb begin
    txPattern  = '0;
    rxExpected = '0;
    for (int i = 0; i < DW / 8; i++) begin
      txPattern[8*i +: 8]  = txCount_q[7:0] + 8'(i);
      rxExpected[8*i +: 8] = rxCount_q[7:0] + 8'(i) + INCREMENT;
    end
  end

  assign rxMismatch = (rx_data != rxExpected) || (rx_dest != DEST) ||
                      (rx_last != lastOf(rxCount_q));

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: start is only honoured outside RUN; the last rx handshake finishes the run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (rxHandshake && (rxCount_q + 32'd1 == NUM_PKTS)) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Counter next-state: restart clears, handshakes count, mismatches and stray DONE beats add one error each.
  always_comb begin
    txCount_d  = txCount_q;
    rxCount_d  = rxCount_q;
    errCount_d = errCount_q;
    if (clearCounts) begin
      txCount_d  = '0;
      rxCount_d  = '0;
      errCount_d = '0;
    end else begin
      if (txHandshake) txCount_d = txCount_q + 32'd1;
      if (rxHandshake && state_q == RUN) rxCount_d = rxCount_q + 32'd1;
      if (rxHandshake && ((state_q == RUN && rxMismatch) || state_q == DONE) &&
          errCount_q != 16'hFFFF)
        errCount_d = errCount_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      txCount_q  <= '0;
      rxCount_q  <= '0;
      errCount_q <= '0;
    end else begin
      txCount_q  <= txCount_d;
      rxCount_q  <= rxCount_d;
      errCount_q <= errCount_d;
    end
  end

  // Output decode from state and counters.
  always_comb begin
    busy     = (state_q == RUN);
    done     = (state_q == DONE);
    pass     = (state_q == DONE) && (errCount_q == 16'd0);
    tx_valid = (state_q == RUN) && (txCount_q < NUM_PKTS) && txAllow;
    rx_ready = ((state_q == RUN) && rxAllow) || (state_q == DONE);
    tx_data  = txPattern;
    tx_dest  = DEST;
    tx_last  = tx_valid && lastOf(txCount_q);
  end

  assign err_count = errCount_q;
  assign tx_count  = txCount_q;
  assign rx_count  = rxCount_q;

endmodule

// File: tb/tb_sb_loopback_tester.sv
// Directed bench for sb_loopback_tester with a combinational incrementing
// loopback responder wired between tx and rx.
module tb_sb_loopback_tester;

`ifdef SB_LOOPBACK_TESTER_STALL_EN
  localparam logic [31:0] NP = 32'd64;
`else
  localparam logic [31:0] NP = 32'd4;
`endif

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] tx_data, rx_data, tx_dest, rx_dest, tx_count, rx_count;
  logic        tx_last, tx_valid, tx_ready, rx_last, rx_valid, rx_ready;
  logic        busy, done, pass;
  logic [15:0] err_count;

  logic [7:0]  respIncr = 8'd1;
  logic        holdTx = 1'b0;
  logic        injectOn = 1'b0;
  logic [31:0] respData;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Responder: adds respIncr to every byte; holdTx models a stalled responder; injectOn forces a stray beat.
  always_comb begin
    for (int i = 0; i < 4; i++) respData[8*i +: 8] = tx_data[8*i +: 8] + respIncr;
  end
  assign tx_ready = !holdTx && !injectOn && rx_ready;
  assign rx_valid = injectOn || (tx_valid && !holdTx);
  assign rx_data  = injectOn ? 32'hDEADBEEF : respData;
  assign rx_dest  = injectOn ? 32'h000000A5 : tx_dest;
  assign rx_last  = injectOn ? 1'b0 : tx_last;

  sb_loopback_tester #(
    .DW(32), .INCREMENT(8'd1), .NUM_PKTS(NP), .BURST_LEN(32'd2), .DEST(32'hA5)
  ) dut (
    .clk(clk), .nreset(nreset), .start(start),
    .tx_data(tx_data), .tx_dest(tx_dest), .tx_last(tx_last), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_dest(rx_dest), .rx_last(rx_last),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .tx_count(tx_count), .rx_count(rx_count)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pulse start across one rising edge; returns at the falling edge after it.
  task automatic applyStimulus();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_done_in_budget"}, 64'(done), 64'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_pass"}, 64'(pass), 64'd0);
    checkOutput({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
    checkOutput({tag, "_tx_last"}, 64'(tx_last), 64'd0);
    checkOutput({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
    checkOutput({tag, "_tx_data"}, 64'(tx_data), 64'h03020100);
    checkOutput({tag, "_tx_dest"}, 64'(tx_dest), 64'hA5);
    checkOutput({tag, "_err"}, 64'(err_count), 64'd0);
    checkOutput({tag, "_tx_count"}, 64'(tx_count), 64'd0);
    checkOutput({tag, "_rx_count"}, 64'(rx_count), 64'd0);
  endtask

  initial begin
    // Reset and check idle outputs
    #12 nreset = 1'b1;
    @(negedge clk);
    checkResetState("reset");

`ifdef SB_LOOPBACK_TESTER_STALL_EN
    begin
      bit sawRxStall = 1'b0;
      bit sawTxGap = 1'b0;
      int n = 0;
      applyStimulus();
      while (!done && n < 4000) begin
        if (busy && !rx_ready) sawRxStall = 1'b1;
        if (busy && !tx_valid && tx_count < NP) sawTxGap = 1'b1;
        @(negedge clk);
        n++;
      end
      checkOutput("stall_done", 64'(done), 64'd1);
      checkOutput("stall_pass", 64'(pass), 64'd1);
      checkOutput("stall_err", 64'(err_count), 64'd0);
      checkOutput("stall_tx_count", 64'(tx_count), 64'd64);
      checkOutput("stall_rx_count", 64'(rx_count), 64'd64);
      checkOutput("stall_saw_rx_stall", 64'(sawRxStall), 64'd1);
      checkOutput("stall_saw_tx_gap", 64'(sawTxGap), 64'd1);
    end
`else
    // Clean run: four words, last on words 1 and 3
    applyStimulus();
    checkOutput("run1_busy", 64'(busy), 64'd1);
    checkOutput("run1_valid", 64'(tx_valid), 64'd1);
    checkOutput("run1_w0_data", 64'(tx_data), 64'h03020100);
    checkOutput("run1_w0_last", 64'(tx_last), 64'd0);
    @(negedge clk);
    checkOutput("run1_w1_data", 64'(tx_data), 64'h04030201);
    checkOutput("run1_w1_last", 64'(tx_last), 64'd1);
    @(negedge clk);
    checkOutput("run1_w2_data", 64'(tx_data), 64'h05040302);
    checkOutput("run1_w2_last", 64'(tx_last), 64'd0);
    @(negedge clk);
    checkOutput("run1_w3_data", 64'(tx_data), 64'h06050403);
    checkOutput("run1_w3_last", 64'(tx_last), 64'd1);
    checkOutput("run1_w3_done_low", 64'(done), 64'd0);
    @(negedge clk);
    checkOutput("run1_done", 64'(done), 64'd1);
    checkOutput("run1_pass", 64'(pass), 64'd1);
    checkOutput("run1_err", 64'(err_count), 64'd0);
    checkOutput("run1_tx_count", 64'(tx_count), 64'd4);
    checkOutput("run1_rx_count", 64'(rx_count), 64'd4);
    checkOutput("run1_busy_low", 64'(busy), 64'd0);
    checkOutput("run1_valid_low", 64'(tx_valid), 64'd0);

    // Responder with the wrong increment: every word mismatches
    respIncr = 8'd2;
    applyStimulus();
    waitDone("bad_incr", 20);
    checkOutput("bad_incr_err", 64'(err_count), 64'd4);
    checkOutput("bad_incr_pass", 64'(pass), 64'd0);
    respIncr = 8'd1;

    // Responder stalled for ten cycles: the first offer must hold
    holdTx = 1'b1;
    applyStimulus();
    for (int c = 0; c < 10; c++) begin
      if (c == 0 || c == 9) begin
        checkOutput("hold_valid", 64'(tx_valid), 64'd1);
        checkOutput("hold_data", 64'(tx_data), 64'h03020100);
        checkOutput("hold_tx_count", 64'(tx_count), 64'd0);
      end
      @(negedge clk);
    end
    holdTx = 1'b0;
    waitDone("hold", 20);
    checkOutput("hold_pass", 64'(pass), 64'd1);

    // Reset partway through a run, then a fresh run
    applyStimulus();
    @(negedge clk);
    @(negedge clk);
    checkOutput("midreset_tx_count_before", 64'(tx_count), 64'd2);
    nreset = 1'b0;
    #1;
    checkResetState("midreset");
    @(negedge clk) nreset = 1'b1;
    applyStimulus();
    waitDone("after_reset", 20);
    checkOutput("after_reset_pass", 64'(pass), 64'd1);

    // Restart from DONE, then inject a stray beat in DONE
    applyStimulus();
    checkOutput("restart_tx_count_cleared", 64'(tx_count), 64'd0);
    checkOutput("restart_busy", 64'(busy), 64'd1);
    waitDone("restart", 20);
    checkOutput("restart_pass", 64'(pass), 64'd1);
    checkOutput("restart_rx_count", 64'(rx_count), 64'd4);
    injectOn = 1'b1;
    @(negedge clk) injectOn = 1'b0;
    checkOutput("stray_err", 64'(err_count), 64'd1);
    checkOutput("stray_pass", 64'(pass), 64'd0);
    checkOutput("stray_rx_count", 64'(rx_count), 64'd4);
    checkOutput("stray_done", 64'(done), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
